// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state and direction encodings for the button event scheduler
//
// Contents:
//   state_t : scheduler FSM states (ST_IDLE, ST_HOLD, ST_REPEAT, ST_LOCKOUT)
//   dir_t   : step direction of the press being tracked (DIR_INC, DIR_DEC)

package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,   // also the "armed" state when auto-repeat is not built
        ST_REPEAT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-bit rising-edge detector for a debounced button level
//
// Ports:
//   i_clock : system clock
//   i_reset : synchronous active-high reset
//   i_level : debounced button level
//   o_rise  : high in the cycle where i_level is high and was low on the previous edge

module rise_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_level,
    output logic o_rise
);

    logic prev;

    // Reset loads the live level rather than 0 so a button held through
    // reset is not mistaken for a fresh press once reset releases.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            prev <= i_level;
        end else begin
            prev <= i_level;
        end
    end

    assign o_rise = i_level & ~prev;

endmodule

// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - turns inc/dec/clear button levels into counter steps
//
// Optional feature: define BUTTON_AUTO_REPEAT_EN to build the hold/auto-repeat
// timer. Without it every press yields exactly one step.
//
// Ports:
//   i_clock    : system clock
//   i_reset    : synchronous active-high reset
//   i_inc      : debounced increment level
//   i_dec      : debounced decrement level
//   i_clear    : debounced clear level
//   o_counter  : current count (WIDTH bits)
//   o_step     : one-cycle pulse whenever o_counter is written
//   o_at_limit : last inc/dec was blocked by a saturation limit

import button_pkg::*;

module button_event_scheduler #(
    parameter int WIDTH         = 4,
    parameter int SATURATE      = 0,
    parameter int HOLD_DELAY    = 12000000,
    parameter int REPEAT_PERIOD = 3000000
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_counter,
    output logic             o_step,
    output logic             o_at_limit
);

    logic rise_inc, rise_dec, rise_clear;

    rise_detect u_rise_inc   (.i_clock(i_clock), .i_reset(i_reset), .i_level(i_inc),   .o_rise(rise_inc));
    rise_detect u_rise_dec   (.i_clock(i_clock), .i_reset(i_reset), .i_level(i_dec),   .o_rise(rise_dec));
    rise_detect u_rise_clear (.i_clock(i_clock), .i_reset(i_reset), .i_level(i_clear), .o_rise(rise_clear));

    state_t state;
    dir_t   dir;

    // Candidate results for both directions; the FSM picks one when it steps.
    logic             up_blocked, dn_blocked;
    logic [WIDTH-1:0] cnt_up, cnt_dn;

    always_comb begin
        up_blocked = (SATURATE != 0) && (o_counter == {WIDTH{1'b1}});
        dn_blocked = (SATURATE != 0) && (o_counter == {WIDTH{1'b0}});
        cnt_up     = up_blocked ? o_counter : o_counter + 1'b1;
        cnt_dn     = dn_blocked ? o_counter : o_counter - 1'b1;
    end

    // Levels of the button that started the current press and of its opposite.
    logic dir_level, opp_level;
    assign dir_level = (dir == DIR_DEC) ? i_dec : i_inc;
    assign opp_level = (dir == DIR_DEC) ? i_inc : i_dec;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int TW = $clog2(((HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_DELAY - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_PERIOD - 1);

    logic [TW-1:0] timer;
`else
    logic unused_cfg;
    assign unused_cfg = ^{HOLD_DELAY, REPEAT_PERIOD};
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_counter  <= '0;
            o_step     <= 1'b0;
            o_at_limit <= 1'b0;
            state      <= ST_IDLE;
            dir        <= DIR_INC;
`ifdef BUTTON_AUTO_REPEAT_EN
            timer      <= '0;
`endif
        end else begin
            o_step <= 1'b0;
            if (rise_clear) begin
                o_counter  <= '0;
                o_step     <= 1'b1;
                o_at_limit <= 1'b0;
                state      <= ST_IDLE;
`ifdef BUTTON_AUTO_REPEAT_EN
                timer      <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise_inc && rise_dec) begin
                            state <= ST_LOCKOUT;
                        end else if (rise_inc || rise_dec) begin
                            // A new press while the other button is already
                            // held is a conflict, same as pressing both.
                            if (rise_inc ? i_dec : i_inc) begin
                                state <= ST_LOCKOUT;
                            end else begin
                                o_counter  <= rise_dec ? cnt_dn : cnt_up;
                                o_at_limit <= rise_dec ? dn_blocked : up_blocked;
                                o_step     <= 1'b1;
                                dir        <= rise_dec ? DIR_DEC : DIR_INC;
                                state      <= ST_HOLD;
`ifdef BUTTON_AUTO_REPEAT_EN
                                timer      <= '0;
`endif
                            end
                        end
                    end
`ifdef BUTTON_AUTO_REPEAT_EN
                    ST_HOLD, ST_REPEAT: begin
                        if (!dir_level) begin
                            state <= ST_IDLE;
                        end else if (opp_level) begin
                            state <= ST_LOCKOUT;
                        end else if (timer == ((state == ST_HOLD) ? HOLD_LAST : REP_LAST)) begin
                            o_counter  <= (dir == DIR_DEC) ? cnt_dn : cnt_up;
                            o_at_limit <= (dir == DIR_DEC) ? dn_blocked : up_blocked;
                            o_step     <= 1'b1;
                            state      <= ST_REPEAT;
                            timer      <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
`else
                    ST_HOLD: begin
                        // Armed: wait for release, no further steps.
                        if (!dir_level) begin
                            state <= ST_IDLE;
                        end else if (opp_level) begin
                            state <= ST_LOCKOUT;
                        end
                    end
`endif
                    ST_LOCKOUT: begin
                        if (!i_inc && !i_dec) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_event_scheduler.sv
// tb/tb_button_event_scheduler.sv - self-checking bench for button_event_scheduler

module tb_button_event_scheduler;

    localparam int HD = 8;
    localparam int RP = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int EXP_HOLD_STEPS = AUTO ? 7 : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic clr = 1'b0;
    logic [3:0] cnt_w, cnt_s;
    logic step_w, step_s, lim_w, lim_s;

    always #5 clk = ~clk;

    button_event_scheduler #(.WIDTH(4), .SATURATE(0), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)) dut_wrap (
        .i_clock(clk), .i_reset(rst), .i_inc(inc), .i_dec(dec), .i_clear(clr),
        .o_counter(cnt_w), .o_step(step_w), .o_at_limit(lim_w)
    );

    button_event_scheduler #(.WIDTH(4), .SATURATE(1), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)) dut_sat (
        .i_clock(clk), .i_reset(rst), .i_inc(inc), .i_dec(dec), .i_clear(clr),
        .o_counter(cnt_s), .o_step(step_s), .o_at_limit(lim_s)
    );

    wire [11:0] dut_vec = {cnt_w, step_w, lim_w, cnt_s, step_s, lim_s};

    int checks = 0;
    int errors = 0;

    // Reference model: a press is tracked by its age in cycles since the press
    // step; repeats fall at age HD, HD+RP, HD+2RP, ...
    localparam int M_IDLE = 0, M_PRESSED = 1, M_LOCKED = 2;
    bit p_inc, p_dec, p_clr;
    int mode, age, mw, ms;
    bit m_down, m_step, m_lim;
    logic [11:0] mdl_vec;

    task automatic model_apply(input bit down);
        m_step = 1'b1;
        mw = (mw + (down ? 15 : 1)) % 16;
        if (down ? (ms == 0) : (ms == 15)) begin
            m_lim = 1'b1;
        end else begin
            ms = down ? ms - 1 : ms + 1;
            m_lim = 1'b0;
        end
    endtask

    task automatic model_pack();
        mdl_vec = {mw[3:0], m_step, 1'b0, ms[3:0], m_step, m_lim};
    endtask

    task automatic model_reset(input bit a, input bit b, input bit c);
        p_inc = a; p_dec = b; p_clr = c;
        mode = M_IDLE; age = 0; mw = 0; ms = 0; m_down = 1'b0; m_step = 1'b0; m_lim = 1'b0;
        model_pack();
    endtask

    task automatic model_edge(input bit a, input bit b, input bit c);
        bit ri, rd, rc;
        ri = a & ~p_inc;
        rd = b & ~p_dec;
        rc = c & ~p_clr;
        m_step = 1'b0;
        if (rc) begin
            mw = 0; ms = 0; m_lim = 1'b0; m_step = 1'b1; mode = M_IDLE;
        end else if (mode == M_IDLE) begin
            if (ri && rd) begin
                mode = M_LOCKED;
            end else if (ri || rd) begin
                if (ri ? b : a) begin
                    mode = M_LOCKED;
                end else begin
                    mode = M_PRESSED; m_down = rd; age = 0;
                    model_apply(rd);
                end
            end
        end else if (mode == M_PRESSED) begin
            age++;
            if (!(m_down ? b : a)) mode = M_IDLE;
            else if (m_down ? a : b) mode = M_LOCKED;
            else if (AUTO && age >= HD && ((age - HD) % RP) == 0) model_apply(m_down);
        end else if (!a && !b) begin
            mode = M_IDLE;
        end
        p_inc = a; p_dec = b; p_clr = c;
        model_pack();
    endtask

    task automatic cycle(input bit a, input bit b, input bit c);
        @(negedge clk);
        rst = 1'b0; inc = a; dec = b; clr = c;
        @(posedge clk);
        model_edge(a, b, c);
        #1;
    endtask

    task automatic apply_reset(input bit a, input bit b, input bit c);
        @(negedge clk);
        rst = 1'b1; inc = a; dec = b; clr = c;
        @(posedge clk);
        model_reset(a, b, c);
        #1;
    endtask

    task automatic test_reset();
        apply_reset(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_vec !== 12'h000) begin
            errors++; $display("FAIL reset_state: got %h want 000", dut_vec);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (dut_vec !== 12'h000 || dut_vec !== mdl_vec) begin
                errors++; $display("FAIL reset_held_inc cyc %0d: got %h want 000", i, dut_vec);
            end
        end
    endtask

    task automatic test_hold_repeat();
        int n;
        bit a;
        n = 0;
        apply_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            a = (i >= 10 && i < 40);
            cycle(a, 1'b0, 1'b0);
            n += int'(step_w);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL hold_model cyc %0d: got %h want %h", i, dut_vec, mdl_vec);
            end
        end
        checks++;
        if (n != EXP_HOLD_STEPS) begin
            errors++; $display("FAIL hold_step_count: got %0d want %0d", n, EXP_HOLD_STEPS);
        end
        checks++;
        if (cnt_w !== 4'(EXP_HOLD_STEPS)) begin
            errors++; $display("FAIL hold_counter: got %0d want %0d", cnt_w, EXP_HOLD_STEPS);
        end
    endtask

    task automatic test_wrap_saturate();
        logic [11:0] exp_vec;
        apply_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL fill_model press %0d: got %h want %h", i, dut_vec, mdl_vec);
            end
            cycle(1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0);
        exp_vec = {4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1};
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL inc_at_top: got %h want %h", dut_vec, exp_vec);
        end
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        exp_vec = {4'd15, 1'b1, 1'b0, 4'd14, 1'b1, 1'b0};
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL dec_after_limit: got %h want %h", dut_vec, exp_vec);
        end
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lockout();
        int n;
        n = 0;
        apply_reset(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (dut_vec !== 12'h000) begin
            errors++; $display("FAIL dual_rise: got %h want 000", dut_vec);
        end
        for (int i = 0; i < 12; i++) begin cycle(1'b1, 1'b1, 1'b0); n += int'(step_w | step_s); end
        for (int i = 0; i < 12; i++) begin cycle(1'b1, 1'b0, 1'b0); n += int'(step_w | step_s); end
        for (int i = 0; i < 2; i++)  begin cycle(1'b0, 1'b0, 1'b0); n += int'(step_w | step_s); end
        checks++;
        if (n != 0 || cnt_w !== 4'd0) begin
            errors++; $display("FAIL lockout_steps: got %0d steps cnt %0d want 0 steps cnt 0", n, cnt_w);
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (cnt_w !== 4'd1 || step_w !== 1'b1 || cnt_s !== 4'd1) begin
            errors++; $display("FAIL post_lockout_inc: got cnt %0d step %b want cnt 1 step 1", cnt_w, step_w);
        end
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        int n;
        n = 0;
        apply_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < HD + RP + 2; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL dec_hold_model cyc %0d: got %h want %h", i, dut_vec, mdl_vec);
            end
        end
        cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (cnt_w !== 4'd0 || step_w !== 1'b1 || cnt_s !== 4'd0 || lim_s !== 1'b0) begin
            errors++; $display("FAIL clear_pulse: got cnt %0d step %b lim %b want cnt 0 step 1 lim 0", cnt_w, step_w, lim_s);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, (i < 5));
            n += int'(step_w | step_s);
        end
        checks++;
        if (n != 0 || cnt_w !== 4'd0) begin
            errors++; $display("FAIL after_clear: got %0d steps cnt %0d want 0 steps cnt 0", n, cnt_w);
        end
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit a, b, c;
        a = 1'b0; b = 1'b0; c = 1'b0;
        apply_reset(a, b, c);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) a = ~a;
            if ($urandom_range(0, 5) == 0) b = ~b;
            if ($urandom_range(0, 19) == 0) c = ~c;
            if ($urandom_range(0, 299) == 0) begin
                apply_reset(a, b, c);
            end else begin
                cycle(a, b, c);
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL random cyc %0d in %b%b%b: got %h want %h", i, a, b, c, dut_vec, mdl_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_repeat();
        test_wrap_saturate();
        test_lockout();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Sequences the debounced inc/dec/clear button levels into single-cycle counter operations on one synchronous clock domain.
- Detects press edges, arbitrates simultaneous presses by fixed priority, and optionally auto-repeats a held inc/dec.
- Owns the counter register with wrap or saturate arithmetic.
- Sits between the per-button debouncers and whatever displays or consumes the count, e.g. the LED/7-seg driver.

Parameters:
- WIDTH, 4: counter width in bits.
- SATURATE, 0: 0 = modulo 2^WIDTH wrap; 1 = clamp at 0 and at 2^WIDTH-1.
- HOLD_DELAY, 12000000: cycles from the first step of a held press to its first repeat step; must be ≥2.
- REPEAT_PERIOD, 3000000: cycles between successive repeat steps; must be ≥1.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_inc  in  1  debounced increment level.
- i_dec  in  1  debounced decrement level.
- i_clear  in  1  debounced clear level.
- o_counter  out  WIDTH  current count.
- o_step  out  1  one-cycle pulse on each edge where o_counter is written (inc, dec or clear), including no-change writes at saturation.
- o_at_limit  out  1  high when SATURATE=1 and the last inc/dec was blocked by a limit; cleared by the next successful step or clear.

Behaviour:
- One clock (i_clock); reset (i_reset) is synchronous and active-high.
- Reset values:
  - o_counter=0, o_step=0, o_at_limit=0, FSM=IDLE, timer=0.
  - Previous-level registers load the current i_inc/i_dec/i_clear, so a button held through reset produces no step after reset.
- Edge detect: rise_x = i_x & ~prev_x, sampled each clock. A step caused by a rise sampled at edge t is visible in o_counter immediately after edge t; o_step is high for that one cycle.
- Priority in a single cycle:
  - clear rise beats everything: counter←0, FSM→IDLE, timer cleared.
  - inc rise and dec rise together: neither applied, FSM→LOCKOUT.
- FSM states IDLE, HOLD, REPEAT, LOCKOUT:
  - IDLE: an inc rise (dec low) steps +1 and goes to HOLD with dir=inc, timer=0. A dec rise (inc low) behaves the same with dir=dec.
  - HOLD: timer counts while the dir button stays high. At timer=HOLD_DELAY-1 the block steps, goes to REPEAT, and sets timer=0.
  - REPEAT: at timer=REPEAT_PERIOD-1 the block steps and sets timer=0.
  - HOLD/REPEAT, dir button low: → IDLE with no step.
  - HOLD/REPEAT, opposite button high: → LOCKOUT with no step.
  - LOCKOUT: no steps. Goes to IDLE only when i_inc and i_dec are both low. Clear is still honoured.
- Clear is edge-only and never repeats; holding i_clear does not block inc/dec rises.
- Arithmetic:
  - SATURATE=0: +1 at all-ones wraps to 0; -1 at 0 wraps to all-ones.
  - SATURATE=1: +1 at all-ones or -1 at 0 leaves the count unchanged, pulses o_step, and sets o_at_limit.
- Timer width: $clog2(max(HOLD_DELAY,REPEAT_PERIOD)+1).

Optional Feature:
- Macro BUTTON_AUTO_REPEAT_EN.
- Defined: HOLD/REPEAT operate as described.
- Undefined:
  - HOLD and REPEAT states, timer, HOLD_DELAY and REPEAT_PERIOD logic are not synthesised.
  - A press produces exactly one step. The FSM reduces to IDLE/ARMED/LOCKOUT: ARMED waits for release of the dir button, and opposite-button behaviour is unchanged.

Decomposition:
- Shared package/include button_pkg:
  - FSM state encoding (2-bit localparams ST_IDLE, ST_HOLD, ST_REPEAT, ST_LOCKOUT).
  - Direction encoding DIR_INC/DIR_DEC.
- Sub-module rise_detect (1-bit, synchronous reset that loads the current input), instantiated once per button.

Test Plan:
- Params WIDTH=4, SATURATE=0, HOLD_DELAY=8, REPEAT_PERIOD=4, macro defined.
  - Hold i_inc from cycle 10 to 40 → steps at cycles 10, 18, 22, 26, 30, 34, 38; o_counter=7; no step after release.
- Count at 15, single inc pulse → o_counter=0, one o_step.
- SATURATE=1, count 15, inc press → o_counter stays 15, o_step=1, o_at_limit=1. A following dec press → 14, o_at_limit=0.
- i_inc and i_dec rise in the same cycle → no step, LOCKOUT. Release dec only → still no steps. Release both, then press inc → +1.
- Hold i_dec into REPEAT, then pulse i_clear → o_counter=0 that cycle, FSM IDLE, no further decrements while i_dec stays high.
- i_inc held high across i_reset deassertion → o_counter stays 0, no o_step. Macro undefined, 30-cycle inc hold → exactly one step.
